// File: rtl/branch_pkg.sv
// Shared types and constants for the branch condition unit.
// Holds the request type enum, the condition codes and the NZCV bit positions.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_CBZ  = 2'b01,
    BR_CBNZ = 2'b10,
    BR_COND = 2'b11
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether cond passes for
// the given NZCV flags.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = nzcv[N_IDX];
  assign z_s = nzcv[Z_IDX];
  assign c_s = nzcv[C_IDX];
  assign v_s = nzcv[V_IDX];

  // condition decode table; AL and NV both pass unconditionally
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_HS: pass = c_s;
      COND_LO: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~(c_s & ~z_s);
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = ~(~z_s & (n_s == v_s));
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch resolution unit: one-cycle branch decision for B/CBZ/CBNZ/B.cond,
// NZCV flag register with optional same-cycle forwarding, and statistics.
module branch_cond_unit
  import branch_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_flags,
  input  logic [3:0]       flag_in,
  input  logic             req_valid,
  input  logic [1:0]       req_type,
  input  logic [3:0]       cond,
  input  logic             reg_zero,
  input  logic             flush,
  output logic             resp_valid,
  output logic             take,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [3:0] flags_used_s;
  logic       cond_pass_s;
  logic       decision_s;
  logic       accept_s;

  // forward a same-cycle flag write to B.cond when enabled
  always_comb begin
    flags_used_s = flags;
    if ((FWD_EN != 0) && set_flags) begin
      flags_used_s = flag_in;
    end else begin
      flags_used_s = flags;
    end
  end

  cond_eval u_cond_eval (
    .cond (cond),
    .nzcv (flags_used_s),
    .pass (cond_pass_s)
  );

  // branch decision by request type
  always_comb begin
    decision_s = 1'b0;
    case (br_type_e'(req_type))
      BR_B:    decision_s = 1'b1;
      BR_CBZ:  decision_s = reg_zero;
      BR_CBNZ: decision_s = ~reg_zero;
      BR_COND: decision_s = cond_pass_s;
      default: decision_s = 1'b0;
    endcase
  end

  assign accept_s = req_valid & ~flush;

  // response, flag register and statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      take       <= 1'b0;
      flags      <= 4'b0000;
      branch_cnt <= {CNT_W{1'b0}};
      taken_cnt  <= {CNT_W{1'b0}};
    end else begin
      resp_valid <= accept_s;
      take       <= accept_s & decision_s;
      // flush cancels only the request, never the flag write
      if (set_flags) begin
        flags <= flag_in;
      end
      if (accept_s) begin
        branch_cnt <= branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s && decision_s) begin
        taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter FWD_EN, default 1, meaning: a same-cycle flag write is forwarded to a same-cycle B.cond request.
REQ-002 Parameter CNT_W, default 16, meaning: width of the statistics counters.
REQ-003 Port clk, input, 1, meaning: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, meaning: asynchronous, active-high reset.
REQ-005 Port set_flags, input, 1, meaning: capture flag_in at this edge.
REQ-006 Port flag_in, input, 4, meaning: ALU flags {N,Z,C,V}, N at bit 3.
REQ-007 Port req_valid, input, 1, meaning: a branch request is present this cycle.
REQ-008 Port req_type, input, 2, meaning: 00 B, 01 CBZ, 10 CBNZ, 11 B.cond.
REQ-009 Port cond, input, 4, meaning: condition code, used only for B.cond.
REQ-010 Port reg_zero, input, 1, meaning: 1 when the tested 64-bit register is all zeros (output of the 64-input zero-detect NOR).
REQ-011 Port flush, input, 1, meaning: cancel the request presented this cycle.
REQ-012 Port resp_valid, output, 1, meaning: a branch decision is available.
REQ-013 Port take, output, 1, meaning: the branch is taken; meaningful only while resp_valid=1.
REQ-014 Port flags, output, 4, meaning: stored NZCV register.
REQ-015 Port branch_cnt, output, CNT_W, meaning: count of resolved requests.
REQ-016 Port taken_cnt, output, CNT_W, meaning: count of taken requests.

Function
REQ-017 Latency SHALL be exactly 1 cycle: a request accepted at edge t SHALL produce resp_valid=1 and its take value during cycle t+1.
REQ-018 When req_valid=0, or flush=1 at the edge, resp_valid SHALL be 0 for the following cycle; flush SHALL take priority over req_valid.
REQ-019 Decisions SHALL be: B=1; CBZ=reg_zero; CBNZ=~reg_zero; B.cond=cond_eval(cond, flags used).
REQ-020 B.cond SHALL decode as follows: 0000 EQ Z; 0001 NE ~Z; 0010 HS C; 0011 LO ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~(C&~Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE ~(~Z&(N==V)); 1110 and 1111 always 1.
REQ-021 Flags used for B.cond SHALL be flag_in when set_flags=1 in the same cycle and FWD_EN=1; otherwise the stored flags.
REQ-022 The flags register SHALL load flag_in at every edge with set_flags=1, and SHALL hold its value otherwise.
REQ-023 flush SHALL NOT block a flag write in the same cycle.
REQ-024 CBZ, CBNZ and B SHALL ignore the flags and cond inputs.
REQ-025 When resp_valid=0, take SHALL be 0.
REQ-026 branch_cnt SHALL increment by 1 at each accepted, non-flushed request.
REQ-027 taken_cnt SHALL increment by 1 at each accepted, non-flushed request whose decision is take=1.
REQ-028 Both counters SHALL wrap modulo 2^CNT_W.
REQ-029 Back-to-back requests SHALL be accepted every cycle with no stall.

Reset
REQ-030 While reset=1, all of the following SHALL be forced to 0 asynchronously: resp_valid, take, flags, branch_cnt, taken_cnt.
REQ-031 Reset asserted mid-operation SHALL discard any pending response.
REQ-032 The first request after reset deasserts SHALL be accepted at the first rising clk edge.

Structure
REQ-033 Package branch_pkg SHALL hold the following: the req_type enum (BR_B, BR_CBZ, BR_CBNZ, BR_COND); the 4-bit cond code constants; the flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
REQ-034 Condition decoding SHALL be a combinational sub-module cond_eval, taking (cond, nzcv) and returning pass.
REQ-035 All other logic SHALL live in branch_cond_unit.

Verification
REQ-036 Reset then idle: all outputs SHALL be 0; a B request SHALL give resp_valid=1 and take=1 one cycle later, with branch_cnt=1 and taken_cnt=1.
REQ-037 CBZ with reg_zero=1, then CBNZ with reg_zero=1, back-to-back: responses SHALL be take=1 then take=0; branch_cnt=2; taken_cnt=1.
REQ-038 set_flags with flag_in=4'b0100 and a same-cycle B.cond EQ: take=1 with FWD_EN=1; take=0 with FWD_EN=0 (stored flags = 0); flags=4'b0100 afterwards in both cases.
REQ-039 Stored flags 4'b1001 (N=1, V=1): GE SHALL give take=1, LT take=0, GT take=1, LE take=0.
REQ-040 Request with flush=1: resp_valid=0 next cycle and counters unchanged; a simultaneous set_flags SHALL still update flags.
REQ-041 Preload both counters to 16'hFFFF via 65535 taken B requests; the next taken B SHALL wrap both counters to 0; reset asserted mid-cycle SHALL zero all outputs before the next edge.
